// File: rtl/ym3812_env.sv
// ym3812_env
// Envelope and output stage for one two-operator OPL2-style channel.
// Each operator runs its own ADSR envelope (6-bit linear, 63 = full scale).
// Total-level attenuation is applied, the operator magnitude is scaled by the
// attenuated level, and the operators are combined into a signed 12-bit sample.
//
// Ports:
//   clk, resetn        system clock, asynchronous active-low reset
//   din                register write data
//   wr_ad1/2           attack rate din[7:4], decay rate din[3:0]
//   wr_sr1/2           sustain level din[7:4], release rate din[3:0]
//   wr_tl1/2           total level attenuation din[5:0]
//   wr_conn            connection bit din[0] (1 = additive, 0 = carrier only)
//   play               key-on level
//   neg1/2, value1/2   operator sign and magnitude from the oscillator stage
//   sample             signed two's-complement channel output
//   sample_valid       one-clock strobe marking the sample of a new audio tick

module ym3812_env #(
  parameter int TICK_DIV = 1500
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  din,
  input  logic        wr_ad1,
  input  logic        wr_ad2,
  input  logic        wr_sr1,
  input  logic        wr_sr2,
  input  logic        wr_tl1,
  input  logic        wr_tl2,
  input  logic        wr_conn,
  input  logic        play,
  input  logic        neg1,
  input  logic        neg2,
  input  logic [3:0]  value1,
  input  logic [3:0]  value2,
  output logic [11:0] sample,
  output logic        sample_valid
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  typedef struct packed {
    logic [2:0]  st;
    logic [5:0]  env;
    logic [14:0] cnt;
  } op_t;

  // Register file
  logic [3:0] ar1_q, ar1_d, dr1_q, dr1_d, sl1_q, sl1_d, rr1_q, rr1_d;
  logic [3:0] ar2_q, ar2_d, dr2_q, dr2_d, sl2_q, sl2_d, rr2_q, rr2_d;
  logic [5:0] tl1_q, tl1_d, tl2_q, tl2_d;
  logic       conn_q, conn_d;

  // Timing and key tracking
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic             play_d_q, play_d_d;
  logic             key_on, key_off;

  // Envelope generators
  op_t op1_q, op1_d, op2_q, op2_d;

  // Output pipeline
  logic [5:0]  lvl1, lvl2;
  logic [9:0]  mag1, mag2;
  logic [10:0] p1_q, p1_d, p2_q, p2_d;
  logic [11:0] sample_q, sample_d;
  logic        valid_pipe_q, valid_pipe_d;
  logic        sample_valid_q, sample_valid_d;

  // Next envelope state for one operator. Key edges take priority over the
  // tick so an edge on a tick cycle only performs the transition. The rate
  // counter fires when it reaches 2^(15-r)-1, which is 0x7FFF >> r.
  function automatic op_t env_next(input op_t cur, input logic rise, input logic fall,
                                   input logic tk, input logic [3:0] ar, input logic [3:0] dr,
                                   input logic [3:0] sl, input logic [3:0] rr);
    op_t         nxt;
    logic [3:0]  rate;
    logic [14:0] lim;
    logic        step;
    logic [5:0]  target;
    nxt = cur;
    case (cur.st)
      ST_ATTACK:  rate = ar;
      ST_DECAY:   rate = dr;
      ST_RELEASE: rate = rr;
      default:    rate = 4'd0;
    endcase
    lim    = 15'h7fff >> rate;
    step   = 1'b0;
    target = 6'd63 - {sl, 2'b00};
    if (rise) begin
      // Re-key from RELEASE keeps the current level
      if (cur.st == ST_IDLE || cur.st == ST_RELEASE) begin
        nxt.st  = ST_ATTACK;
        nxt.cnt = '0;
      end
    end else if (fall) begin
      if (cur.st == ST_ATTACK || cur.st == ST_DECAY || cur.st == ST_SUSTAIN) begin
        nxt.st  = ST_RELEASE;
        nxt.cnt = '0;
      end
    end else if (tk) begin
      if (rate != 4'd0) begin
        if (cur.cnt == lim) begin
          step    = 1'b1;
          nxt.cnt = '0;
        end else begin
          nxt.cnt = cur.cnt + 15'd1;
        end
      end
      case (cur.st)
        ST_IDLE: nxt.env = 6'd0;
        ST_ATTACK: begin
          if (cur.env == 6'd63) begin
            nxt.st  = ST_DECAY;
            nxt.cnt = '0;
          end else if (step) begin
            nxt.env = cur.env + 6'd1;
            if (cur.env == 6'd62) begin
              nxt.st  = ST_DECAY;
              nxt.cnt = '0;
            end
          end
        end
        ST_DECAY: begin
          if (cur.env <= target) begin
            nxt.st  = ST_SUSTAIN;
            nxt.cnt = '0;
          end else if (step) begin
            nxt.env = cur.env - 6'd1;
          end
        end
        ST_RELEASE: begin
          if (cur.env == 6'd0) begin
            nxt.st  = ST_IDLE;
            nxt.cnt = '0;
          end else if (step) begin
            nxt.env = cur.env - 6'd1;
            if (cur.env == 6'd1) begin
              nxt.st  = ST_IDLE;
              nxt.cnt = '0;
            end
          end
        end
        default: nxt.cnt = '0;
      endcase
    end
    return nxt;
  endfunction

  // Register writes
  always_comb begin
    ar1_d = ar1_q; dr1_d = dr1_q; sl1_d = sl1_q; rr1_d = rr1_q;
    ar2_d = ar2_q; dr2_d = dr2_q; sl2_d = sl2_q; rr2_d = rr2_q;
    tl1_d = tl1_q; tl2_d = tl2_q; conn_d = conn_q;
    if (wr_ad1) begin ar1_d = din[7:4]; dr1_d = din[3:0]; end
    if (wr_ad2) begin ar2_d = din[7:4]; dr2_d = din[3:0]; end
    if (wr_sr1) begin sl1_d = din[7:4]; rr1_d = din[3:0]; end
    if (wr_sr2) begin sl2_d = din[7:4]; rr2_d = din[3:0]; end
    if (wr_tl1) tl1_d = din[5:0];
    if (wr_tl2) tl2_d = din[5:0];
    if (wr_conn) conn_d = din[0];
  end

  // Tick prescaler and key edge detection
  assign tick    = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
  assign key_on  = play & ~play_d_q;
  assign key_off = ~play & play_d_q;

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    play_d_d   = play;
    op1_d      = env_next(op1_q, key_on, key_off, tick, ar1_q, dr1_q, sl1_q, rr1_q);
    op2_d      = env_next(op2_q, key_on, key_off, tick, ar2_q, dr2_q, sl2_q, rr2_q);
  end

  // Attenuation, scaling and combining. The valid strobe travels through the
  // same two stages so it marks the sample built from the tick cycle's level.
  always_comb begin
    lvl1 = (op1_q.env >= tl1_q) ? op1_q.env - tl1_q : 6'd0;
    lvl2 = (op2_q.env >= tl2_q) ? op2_q.env - tl2_q : 6'd0;
    mag1 = 10'(value1) * 10'(lvl1);
    mag2 = 10'(value2) * 10'(lvl2);
    p1_d = neg1 ? 11'd0 - {1'b0, mag1} : {1'b0, mag1};
    p2_d = neg2 ? 11'd0 - {1'b0, mag2} : {1'b0, mag2};
    sample_d = conn_q ? {p1_q[10], p1_q} + {p2_q[10], p2_q} : {p2_q[10], p2_q};
    valid_pipe_d   = tick;
    sample_valid_d = valid_pipe_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar1_q <= '0; dr1_q <= '0; sl1_q <= '0; rr1_q <= '0;
      ar2_q <= '0; dr2_q <= '0; sl2_q <= '0; rr2_q <= '0;
      tl1_q <= '0; tl2_q <= '0; conn_q <= 1'b0;
      tick_cnt_q     <= '0;
      play_d_q       <= 1'b0;
      op1_q          <= '{st: ST_IDLE, env: 6'd0, cnt: 15'd0};
      op2_q          <= '{st: ST_IDLE, env: 6'd0, cnt: 15'd0};
      p1_q           <= '0;
      p2_q           <= '0;
      sample_q       <= '0;
      valid_pipe_q   <= 1'b0;
      sample_valid_q <= 1'b0;
    end else begin
      ar1_q <= ar1_d; dr1_q <= dr1_d; sl1_q <= sl1_d; rr1_q <= rr1_d;
      ar2_q <= ar2_d; dr2_q <= dr2_d; sl2_q <= sl2_d; rr2_q <= rr2_d;
      tl1_q <= tl1_d; tl2_q <= tl2_d; conn_q <= conn_d;
      tick_cnt_q     <= tick_cnt_d;
      play_d_q       <= play_d_d;
      op1_q          <= op1_d;
      op2_q          <= op2_d;
      p1_q           <= p1_d;
      p2_q           <= p2_d;
      sample_q       <= sample_d;
      valid_pipe_q   <= valid_pipe_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_ym3812_env.sv
// tb_ym3812_env
// Directed bench for ym3812_env with a 4-clock audio tick. Inputs change 1 time
// unit after a rising edge and outputs are sampled at the same point.

module tb_ym3812_env;

  localparam int W_AD1 = 0, W_AD2 = 1, W_SR1 = 2, W_SR2 = 3, W_TL1 = 4, W_TL2 = 5, W_CONN = 6;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  din;
  logic        wr_ad1, wr_ad2, wr_sr1, wr_sr2, wr_tl1, wr_tl2, wr_conn;
  logic        play, neg1, neg2;
  logic [3:0]  value1, value2;
  logic [11:0] sample;
  logic        sample_valid;

  int checks = 0;
  int errors = 0;

  ym3812_env #(.TICK_DIV(4)) dut (
    .clk(clk), .resetn(resetn), .din(din),
    .wr_ad1(wr_ad1), .wr_ad2(wr_ad2), .wr_sr1(wr_sr1), .wr_sr2(wr_sr2),
    .wr_tl1(wr_tl1), .wr_tl2(wr_tl2), .wr_conn(wr_conn),
    .play(play), .neg1(neg1), .neg2(neg2), .value1(value1), .value2(value2),
    .sample(sample), .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  // One comparison: counts it, and on a mismatch counts and reports the error
  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      $error("[TB] check %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One-clock register write strobe
  task automatic applyStimulus(input int which, input logic [7:0] data);
    din     = data;
    wr_ad1  = (which == W_AD1);
    wr_ad2  = (which == W_AD2);
    wr_sr1  = (which == W_SR1);
    wr_sr2  = (which == W_SR2);
    wr_tl1  = (which == W_TL1);
    wr_tl2  = (which == W_TL2);
    wr_conn = (which == W_CONN);
    @(posedge clk); #1;
    {wr_ad1, wr_ad2, wr_sr1, wr_sr2, wr_tl1, wr_tl2, wr_conn} = '0;
    din = 8'd0;
  endtask

  // Advance to the next sample_valid pulse, bounded
  task automatic tickWait();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (sample_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("valid_timeout", 16'(ok), 16'd1);
  endtask

  task automatic waitPulses(input int n);
    for (int k = 0; k < n; k++) tickWait();
  endtask

  // Watch n pulses, counting sample changes of exactly delta and any other change
  task automatic countSteps(input int n, input int delta, output int steps, output int bad);
    int prev, cur;
    steps = 0;
    bad   = 0;
    prev  = int'($signed(sample));
    for (int k = 0; k < n; k++) begin
      tickWait();
      cur = int'($signed(sample));
      if (cur != prev) begin
        if (cur - prev == delta) steps++;
        else bad++;
      end
      prev = cur;
    end
  endtask

  initial begin
    int steps, bad, span, top;
    bit found;

    resetn = 1'b0; din = 8'd0; play = 1'b0; neg1 = 1'b0; neg2 = 1'b0;
    value1 = 4'd0; value2 = 4'd0;
    {wr_ad1, wr_ad2, wr_sr1, wr_sr2, wr_tl1, wr_tl2, wr_conn} = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_sample", 16'(sample), 16'd0);
    checkOutput("reset_valid", 16'(sample_valid), 16'd0);

    // Default registers: attack rate 0 keeps the level at zero
    play = 1'b1; value1 = 4'd15; value2 = 4'd15; resetn = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      checkOutput("valid_phase", 16'(sample_valid), 16'(c >= 5 && (c % 4) == 1));
      checkOutput("zero_rate_sample", 16'(sample), 16'd0);
    end

    // Fast attack to full scale, then fast release back to zero
    play = 1'b0;
    waitPulses(3);
    applyStimulus(W_AD2, 8'hF0);
    applyStimulus(W_SR2, 8'h0F);
    applyStimulus(W_TL2, 8'h00);
    play = 1'b1;
    countSteps(70, 15, steps, bad);
    checkOutput("attack_steps", 16'(steps), 16'd63);
    checkOutput("attack_bad", 16'(bad), 16'd0);
    checkOutput("attack_top", 16'(sample), 16'd945);
    waitPulses(5);
    checkOutput("sustain_full", 16'(sample), 16'd945);
    play = 1'b0;
    countSteps(70, -15, steps, bad);
    checkOutput("release_steps", 16'(steps), 16'd63);
    checkOutput("release_bad", 16'(bad), 16'd0);
    checkOutput("release_zero", 16'(sample), 16'd0);

    // Decay at rate 14 (one step per 2 ticks) down to 63-4*15 = 3
    applyStimulus(W_AD2, 8'hFE);
    applyStimulus(W_SR2, 8'hFF);
    play = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      tickWait();
      if (sample == 12'd945) found = 1'b1;
    end
    checkOutput("decay_peak_seen", 16'(found), 16'd1);
    span = 0;
    top  = 1;
    for (int k = 0; k < 200; k++) begin
      tickWait();
      span++;
      if (sample == 12'd945) top++;
      if (sample == 12'd45) break;
    end
    checkOutput("decay_span", 16'(span), 16'd120);
    checkOutput("decay_peak_ticks", 16'(top), 16'd2);
    waitPulses(5);
    checkOutput("sustain_level", 16'(sample), 16'd45);

    // Total level larger than the envelope clamps to zero
    applyStimulus(W_TL2, 8'd10);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("tl_clamp", 16'(sample), 16'd0);
    value2 = 4'd8; neg2 = 1'b1;
    applyStimulus(W_SR2, 8'h0F);
    applyStimulus(W_AD2, 8'hF0);
    play = 1'b0;
    waitPulses(8);
    play = 1'b1;
    waitPulses(70);
    checkOutput("tl_negative", 16'(sample), 16'h0E58);

    // Two-clock pipeline latency
    value2 = 4'd4; neg2 = 1'b0;
    @(posedge clk); #1;
    checkOutput("latency_1clk", 16'(sample), 16'h0E58);
    @(posedge clk); #1;
    checkOutput("latency_2clk", 16'(sample), 16'd212);

    // Additive connection with both operators at full scale
    value1 = 4'd15; neg1 = 1'b1; value2 = 4'd15; neg2 = 1'b1;
    applyStimulus(W_TL2, 8'd0);
    applyStimulus(W_TL1, 8'd0);
    applyStimulus(W_SR1, 8'h0F);
    applyStimulus(W_AD1, 8'hF0);
    applyStimulus(W_CONN, 8'h01);
    waitPulses(70);
    checkOutput("conn_both_neg", 16'(sample), 16'h089E);
    neg2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("conn_cancel", 16'(sample), 16'd0);
    neg1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("conn_both_pos", 16'(sample), 16'd1890);
    applyStimulus(W_CONN, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("conn_off", 16'(sample), 16'd945);

    // Re-key in release at level 20 (release rate 13: one step per 4 ticks)
    applyStimulus(W_SR2, 8'h0D);
    play = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 250 && !found; k++) begin
      tickWait();
      if (sample == 12'd300) found = 1'b1;
    end
    checkOutput("release_at_20", 16'(found), 16'd1);
    play = 1'b1;
    countSteps(55, 15, steps, bad);
    checkOutput("rekey_steps", 16'(steps), 16'd43);
    checkOutput("rekey_bad", 16'(bad), 16'd0);
    checkOutput("rekey_top", 16'(sample), 16'd945);

    // Reset in the middle of an attack
    applyStimulus(W_SR2, 8'h0F);
    play = 1'b0;
    waitPulses(70);
    checkOutput("release_idle", 16'(sample), 16'd0);
    play = 1'b1;
    waitPulses(20);
    checkOutput("mid_attack_nonzero", 16'(sample != 12'd0), 16'd1);
    resetn = 1'b0;
    #1;
    checkOutput("async_reset_sample", 16'(sample), 16'd0);
    checkOutput("async_reset_valid", 16'(sample_valid), 16'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    waitPulses(3);
    checkOutput("post_reset_hold", 16'(sample), 16'd0);
    applyStimulus(W_AD2, 8'hF0);
    countSteps(70, 15, steps, bad);
    checkOutput("post_reset_steps", 16'(steps), 16'd63);
    checkOutput("post_reset_bad", 16'(bad), 16'd0);
    checkOutput("post_reset_top", 16'(sample), 16'd945);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ym3812_env.md
# ym3812_env

Envelope and output stage for one two-operator OPL2-style channel. It takes the per-operator sign/magnitude samples (`neg1/value1`, `neg2/value2`) and the key-on flag `play` from the channel oscillator stage. It runs an ADSR envelope per operator, applies total-level attenuation, scales and combines the operators, and delivers a signed 12-bit sample at the audio tick rate to the mixer.

## Interface
- `TICK_DIV`, default 1500: clocks per audio tick (75 MHz / 1500 = 50 kHz).
- `clk` in 1: system clock.
- `resetn` in 1: asynchronous, active-low reset.
- `din` in 8: register write data.
- `wr_ad1`, `wr_ad2` in 1: write attack (`din[7:4]`) and decay (`din[3:0]`) rates for op1/op2.
- `wr_sr1`, `wr_sr2` in 1: write sustain level (`din[7:4]`) and release rate (`din[3:0]`).
- `wr_tl1`, `wr_tl2` in 1: write total level attenuation (`din[5:0]`).
- `wr_conn` in 1: write connection bit (`din[0]`); 1 = additive, 0 = carrier only.
- `play` in 1: key-on level.
- `neg1`, `neg2` in 1: operator sign (1 = negative).
- `value1`, `value2` in 4: operator magnitude.
- `sample` out 12: signed two's-complement channel output.
- `sample_valid` out 1: one-clock strobe marking a new tick's sample.

## Operation
- Reset: all registers, rate counters, tick prescaler, `env1/env2` = 0, both state machines IDLE, `play_d` = 0, `sample` = 0, `sample_valid` = 0.
- Tick prescaler counts 0..TICK_DIV-1. `tick` is asserted on the wrap cycle.
- Key edges are detected every clock from `play` vs `play_d`.
- Per-operator state machine, envelope `env` is 6-bit linear with 63 = full:
  - IDLE: `env` = 0. Rising edge -> ATTACK.
  - ATTACK: step `env` +1 at the attack rate. On reaching 63 -> DECAY.
  - DECAY: step -1 at the decay rate down to target `63 - 4*SL`. At or below target -> SUSTAIN. SL=0 skips to SUSTAIN at 63.
  - SUSTAIN: hold `env`.
  - RELEASE: step -1 at the release rate. At 0 -> IDLE.
  - A falling edge in ATTACK, DECAY or SUSTAIN -> RELEASE.
  - A rising edge in RELEASE -> ATTACK, starting from the current `env`; no reset to 0.
- Rate stepping, per operator:
  - Each operator has a 15-bit rate counter, cleared on every state change.
  - On `tick` with rate r:
    - r = 0: hold.
    - Otherwise: if counter == 2^(15-r) - 1, step `env` and clear the counter; else increment the counter.
  - r = 15 steps every tick.
  - `env` saturates at 0 and 63; there is no wrap.
- Level: `lvl = env - TL`, clamped to 0 when TL > env (6-bit).
- Product: `p = value * lvl` (10-bit, max 945), negated when `neg` = 1 (11-bit signed).
- Output:
  - conn=1: `sample = p1 + p2`, sign-extended to 12 bits (range ±1890).
  - conn=0: `sample = p2`.

## Timing
- Register writes take effect the clock after the strobe. A write coinciding with `tick` is used from the next tick.
- A key edge on a tick cycle performs the transition only; no rate step that tick.
- Envelope state and `env` change only on `tick`, except edge-driven transitions, which happen on the edge clock.
- Pipeline:
  - Stage 1 registers `p1/p2` from the current inputs and `lvl`.
  - Stage 2 registers `sample`.
  - `sample` tracks inputs with 2-clock latency, every clock.
- `sample_valid` = `tick` delayed 2 clocks, one clock wide, aligned with the sample computed from the tick cycle's `env`.
- `resetn` asserted mid-envelope immediately forces the reset values above. Operation resumes from IDLE after deassertion.

## Test plan
- Reset, `TICK_DIV`=4, no writes. Assert `play`, drive `value1/2`=15, `neg`=0 -> `sample`=0 throughout; `sample_valid` pulses every 4 clocks, first at clock 5 after reset release.
- AR=15, DR=0, SL=0, TL=0, conn=0, `play`=1, `value2`=15 -> `env2` reaches 63 after 63 ticks; `sample`=945 steady. Then drop `play` with RR=15 -> `sample` reaches 0 after 63 ticks, state IDLE.
- AR=15, DR=14, SL=15 -> attack to 63, then `env` steps −1 every 2 ticks down to 3, then holds. `sample` with `value2`=15 holds 45.
- TL=10, `env`=5 -> `lvl`=0, `sample`=0. TL=10, `env`=63, `value2`=8, `neg2`=1 -> `sample`=−424 (0xE58).
- conn=1, both ops `env`=63, TL=0, `value1`=15 `neg1`=1, `value2`=15 `neg2`=1 -> `sample`=−1890. `neg2`=0 -> `sample`=0.
- Re-key during RELEASE at `env`=20 -> ATTACK resumes from 20 and reaches 63 after 43 ticks at AR=15. Assert `resetn` mid-attack -> `sample`=0 and state IDLE immediately.
